ifu_idu_queue: RTL
==================

Name: ifu_idu_queue

Overview:
- Instruction queue between the fetch stage (ifu) and the decode stage (idu).
- Captures each {pc, instruction} pair that ifu marks valid and hands pairs to idu in order through a valid/ready handshake.
- Decouples sram fetch latency from decode stalls.
- Discards all in-flight entries on a control-flow redirect (flush).

Parameters:
- DEPTH, 4, number of queue entries; power of two, >= 2.
- XLEN, 32, width of the pc and instruction fields.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  ifu presents a fetched instruction (driven from ifu_send_valid).
- in_ready  output  1  queue can accept an entry this cycle.
- in_pc  input  XLEN  pc of the fetched instruction.
- in_inst  input  XLEN  fetched instruction word.
- out_valid  output  1  head entry is available to idu.
- out_ready  input  1  idu consumes the head entry this cycle.
- out_pc  output  XLEN  pc of the head entry.
- out_inst  output  XLEN  instruction word of the head entry.
- flush  input  1  redirect from exu; discard all entries.
- count  output  $clog2(DEPTH)+1  number of valid entries.
- overflow  output  1  sticky error: in_valid seen while in_ready is low.

Behaviour:
- Storage: circular buffer of DEPTH entries, each {pc, inst}.
  - wr_ptr and rd_ptr are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - Occupancy counter is $clog2(DEPTH)+1 bits, range 0..DEPTH.
- Reset (rst high, asynchronous): wr_ptr=0, rd_ptr=0, count=0, overflow=0. Storage contents are not reset.
- Outputs while rst is high: in_ready=0, out_valid=0, out_pc=0, out_inst=0.
- in_ready = (count != DEPTH) and not rst.
  - in_ready does not depend on out_ready.
  - A full queue never accepts an entry, even when a pop happens in the same cycle.
- push = in_valid & in_ready & ~flush. On push, the entry is written at wr_ptr and wr_ptr increments.
- pop = out_valid & out_ready & ~flush. On pop, rd_ptr increments.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged, and both pointers advance.
- Latency: an entry pushed at edge N is visible on out_* from edge N+1. There is no combinational bypass when the queue is empty.
- out_valid = (count != 0).
- out_pc and out_inst are read combinationally from the entry at rd_ptr when out_valid=1, and are forced to 0 when out_valid=0.
- Flush (synchronous, highest priority):
  - At the edge, wr_ptr=0, rd_ptr=0, count=0.
  - A same-cycle push is dropped and a same-cycle pop has no effect.
  - overflow is unaffected.
- Overflow: set at the edge on which in_valid=1 and in_ready=0 with rst low. It stays set until reset. The offending entry is dropped.
- Wrap-around: pointers roll from DEPTH-1 to 0 with no bubble. FIFO order is preserved across the wrap.
- Reset mid-operation: all entries are discarded immediately (asynchronous). The first push after rst falls is written to slot 0.
- Stable output: while out_valid=1 and out_ready=0, out_pc and out_inst hold stable regardless of pushes.

Test Plan:
- Reset then single entry:
  - Stimulus: assert rst, release, push pc=0x80000000 inst=0x00000413 on one cycle.
  - Required: in_ready=0 during reset and 1 after. out_valid rises on the next cycle with those exact values; count=1. Pop with out_ready=1 gives count=0 and out_valid=0.
- Fill and backpressure:
  - Stimulus: hold out_ready=0 and push 4 entries pc=0x80000000,+4,+8,+C.
  - Required: count=4, in_ready=0, out_pc stays 0x80000000. A 5th in_valid while full sets overflow=1 and count stays 4.
- Simultaneous push/pop and wrap:
  - Stimulus: after 2 entries, push and pop every cycle for 10 cycles.
  - Required: count stays 2, the out_pc sequence is strictly in push order with no drop or duplicate across the pointer wrap.
- Flush:
  - Stimulus: with 3 entries, assert flush together with in_valid=1 (pc=0x80000100) and out_ready=1.
  - Required: next cycle count=0, out_valid=0, the 0x80000100 entry is dropped. The next push is the first entry output.
- Full plus pop:
  - Stimulus: queue full, out_ready=1 and in_valid=1 in the same cycle.
  - Required: in_ready=0, so no push. After the edge count=3 and in_ready=1.
- Async reset mid-stream:
  - Stimulus: with 2 entries, raise rst between clock edges.
  - Required: out_valid=0 and count=0 immediately, without waiting for a clock edge. overflow clears.

Source files
------------

// File: rtl/ifu_idu_queue_if.sv
// Fetch-to-decode handshake bundle: ifu push side (in_*) and idu pop side (out_*).
// The queue takes the slave view; whatever drives both ends takes the master view.
interface ifu_idu_queue_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_inst;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_inst;

    modport master (
        output in_valid, in_pc, in_inst, out_ready,
        input  in_ready, out_valid, out_pc, out_inst
    );

    modport slave (
        input  in_valid, in_pc, in_inst, out_ready,
        output in_ready, out_valid, out_pc, out_inst
    );
endinterface

// File: rtl/ifu_idu_queue.sv
// Circular instruction queue between ifu and idu. In-order {pc, inst} hand-off,
// flush on redirect, and a sticky overflow flag for pushes attempted while full.
module ifu_idu_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    ifu_idu_queue_if.slave         q,
    input  logic                   flush,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [XLEN-1:0] pc_mem   [DEPTH];
    logic [XLEN-1:0] inst_mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

    // in_ready ignores out_ready: a full queue never accepts, even on a same-cycle pop.
    assign q.in_ready  = ~full & ~rst;
    assign q.out_valid = ~empty;
    assign q.out_pc    = q.out_valid ? pc_mem[rd_ptr]   : '0;
    assign q.out_inst  = q.out_valid ? inst_mem[rd_ptr] : '0;

    assign push = q.in_valid  & q.in_ready  & ~flush;
    assign pop  = q.out_valid & q.out_ready & ~flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (q.in_valid & ~q.in_ready)
                overflow <= 1'b1;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + AW'(1);
                if (pop)
                    rd_ptr <= rd_ptr + AW'(1);
                case ({push, pop})
                    2'b10:   count <= count + (AW+1)'(1);
                    2'b01:   count <= count - (AW+1)'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    // Storage is intentionally left out of reset; count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= q.in_pc;
            inst_mem[wr_ptr] <= q.in_inst;
        end
    end
endmodule
